// File: rtl/aurora_tx_framer.sv
// ============================================================================
//  Module   : aurora_tx_framer
//  Function : AXI4-Stream to Aurora lane framer. Buffers user words in a FIFO,
//             wraps each packet in SCP/ECP, fills underruns with I, pads the
//             partial last word, holds an IDLE_GAP of I after ECP and counts
//             frames. Optional clock-compensation bursts under AURORA_CC_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aurora_tx_framer_pkg;
    typedef enum logic [1:0] {
        OS_NONE = 2'd0,
        OS_SCP  = 2'd1,
        OS_ECP  = 2'd2,
        OS_I    = 2'd3
    } ordered_sets_e;
endpackage

module aurora_tx_framer
    import aurora_tx_framer_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int KEEP_W     = DATA_W / 8,
    parameter int FIFO_DEPTH = 8,
    parameter int IDLE_GAP   = 1,
    parameter int CC_PERIOD  = 5000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              link_up,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    output ordered_sets_e     ordered_sets,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              pad_out,
    output logic              cc_out,
    output logic [15:0]       frames_sent
);

    localparam int              c_AW       = $clog2(FIFO_DEPTH);
    localparam int              c_EW       = DATA_W + KEEP_W + 1;
    localparam logic [c_AW:0]   c_DEPTH    = (c_AW + 1)'(FIFO_DEPTH);
    localparam int              c_GAP_W    = $clog2(IDLE_GAP + 2);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(IDLE_GAP);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);
    localparam logic [7:0]      c_PAD_BYTE = 8'h9C;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_ECP    = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

    state_e               r_state, w_state_next;
    logic [c_GAP_W-1:0]   r_gap_cnt, w_gap_next;
    ordered_sets_e        w_os_next;
    logic [DATA_W-1:0]    w_data_next;
    logic                 w_valid_next;
    logic                 w_pad_next;
    logic [15:0]          w_frames_next;
    logic                 w_pop;
    logic                 w_cc_hold;

    // ------------------------------------------------------------------
    // Input FIFO: entry = {tdata, tkeep, tlast}
    // ------------------------------------------------------------------
    logic [c_EW-1:0]   r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic              w_push;
    logic              w_empty;
    logic [c_EW-1:0]   w_rd_word;
    logic [DATA_W-1:0] w_rd_data;
    logic [KEEP_W-1:0] w_rd_keep;
    logic              w_rd_last;

    assign s_axis_tready = !rst && (r_count < c_DEPTH);
    assign w_push        = s_axis_tvalid && s_axis_tready;
    assign w_empty       = (r_count == '0);
    assign w_rd_word     = r_mem[r_rd_ptr];
    assign w_rd_data     = w_rd_word[c_EW-1 -: DATA_W];
    assign w_rd_keep     = w_rd_word[KEEP_W:1];
    assign w_rd_last     = w_rd_word[0];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Last-word padding; an all-zero keep means the whole word is valid
    // ------------------------------------------------------------------
    logic [KEEP_W-1:0] w_keep_eff;
    logic [DATA_W-1:0] w_padded;
    logic [DATA_W-1:0] w_word_out;
    logic              w_word_pad;

    always_comb begin
        w_keep_eff = (w_rd_keep == '0) ? '1 : w_rd_keep;
        w_padded   = w_rd_data;
        for (int j = 0; j < KEEP_W; j++) begin
            if (!w_keep_eff[j]) w_padded[j*8 +: 8] = c_PAD_BYTE;
        end
        w_word_out = w_rd_last ? w_padded : w_rd_data;
        w_word_pad = w_rd_last && (w_keep_eff != '1);
    end

    // ------------------------------------------------------------------
    // Clock compensation
    // ------------------------------------------------------------------
`ifdef AURORA_CC_EN
    localparam int              c_CC_W    = $clog2(CC_PERIOD + 1);
    localparam logic [c_CC_W-1:0] c_CC_LAST = c_CC_W'(CC_PERIOD - 1);

    logic [c_CC_W-1:0] r_cc_cnt;
    logic              r_cc_pending;
    logic [1:0]        r_cc_left;
    logic              w_cc_start;

    // A burst never starts in ECP, so it can only delay SCP/ECP, not replace them
    assign w_cc_start = r_cc_pending && (r_cc_left == 2'd0) && (r_state != ST_ECP);
    assign w_cc_hold  = w_cc_start || (r_cc_left != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cc_cnt     <= '0;
            r_cc_pending <= 1'b0;
            r_cc_left    <= 2'd0;
            cc_out       <= 1'b0;
        end else begin
            r_cc_cnt <= (r_cc_cnt == c_CC_LAST) ? '0 : r_cc_cnt + 1'b1;
            if (w_cc_start)              r_cc_pending <= 1'b0;
            if (r_cc_cnt == c_CC_LAST)   r_cc_pending <= 1'b1;
            if (w_cc_start)              r_cc_left    <= 2'd2;
            else if (r_cc_left != 2'd0)  r_cc_left    <= r_cc_left - 1'b1;
            cc_out <= w_cc_hold;
        end
    end
`else
    assign w_cc_hold = 1'b0;
    // constant 0 for every legal CC_PERIOD
    assign cc_out    = (CC_PERIOD < 0);
`endif

    // ------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_gap_next    = r_gap_cnt;
        w_os_next     = OS_NONE;
        w_data_next   = '0;
        w_valid_next  = 1'b0;
        w_pad_next    = 1'b0;
        w_frames_next = frames_sent;
        w_pop         = 1'b0;

        if (!w_cc_hold) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty && link_up) begin
                        w_os_next    = OS_SCP;
                        w_state_next = ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (!w_empty && link_up) begin
                        w_pop        = 1'b1;
                        w_valid_next = 1'b1;
                        w_data_next  = w_word_out;
                        w_pad_next   = w_word_pad;
                        if (w_rd_last) w_state_next = ST_ECP;
                    end else begin
                        w_os_next = OS_I;
                    end
                end
                ST_ECP: begin
                    w_os_next     = OS_ECP;
                    w_frames_next = frames_sent + 16'd1;
                    w_gap_next    = c_GAP_LOAD;
                    w_state_next  = (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;
                end
                ST_GAP: begin
                    w_os_next  = OS_I;
                    w_gap_next = r_gap_cnt - 1'b1;
                    if (r_gap_cnt <= c_GAP_ONE) w_state_next = ST_IDLE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_gap_cnt    <= '0;
            ordered_sets <= OS_NONE;
            data_out     <= '0;
            data_valid   <= 1'b0;
            pad_out      <= 1'b0;
            frames_sent  <= 16'd0;
        end else begin
            r_state      <= w_state_next;
            r_gap_cnt    <= w_gap_next;
            ordered_sets <= w_os_next;
            data_out     <= w_data_next;
            data_valid   <= w_valid_next;
            pad_out      <= w_pad_next;
            frames_sent  <= w_frames_next;
        end
    end

endmodule

`default_nettype wire
